// File: rtl/addon_pkg.sv
// Shared definitions for the hypot_isqrt_seq datapath: FSM encoding and a width helper.
package addon_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSquare = 2'd1,
    StRoot   = 2'd2,
    StDone   = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: folds two more radicand bits into the
// partial remainder and decides the next root bit.
module isqrt_step
  import addon_pkg::*;
#(
  parameter int unsigned RES_W = 9
) (
  input  logic [RES_W:0]   rem,
  input  logic [RES_W-1:0] root,
  input  logic [1:0]       bits,
  output logic [RES_W:0]   rem_next,
  output logic [RES_W-1:0] root_next
);

  logic [RES_W+2:0] acc;
  logic [RES_W+2:0] sub;
  logic [RES_W+2:0] diff;
  logic             unused_bits;

  assign acc  = {rem, bits};
  assign sub  = {1'b0, root, 2'b01};
  assign diff = acc - sub;

  // The remainder never exceeds twice the partial root, so RES_W+1 bits suffice.
  assign unused_bits = ^{diff[RES_W+2:RES_W+1], root[RES_W-1]};

  always_comb begin
    rem_next  = acc[RES_W:0];
    root_next = {root[RES_W-2:0], 1'b0};
    if (acc >= sub) begin
      rem_next  = diff[RES_W:0];
      root_next = {root[RES_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/hypot_isqrt_seq.sv
// Sequential vector magnitude sqrt(x^2 + y^2): squares once, then extracts one
// root bit per cycle with a restoring square root; valid/ready on both sides.
module hypot_isqrt_seq
  import addon_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          SIGNED = 1'b0,
  parameter bit          ROUND  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_mag,
  output logic              out_exact
);

  localparam int unsigned RES_W = DATA_W + 1;
  localparam int unsigned SH_W  = 2 * RES_W;
  localparam int unsigned CNT_W = clog2(RES_W);

  state_e             state_q;
  logic [DATA_W-1:0]  mag_x_q;
  logic [DATA_W-1:0]  mag_y_q;
  logic [SH_W-1:0]    sum_q;
  logic [RES_W:0]     rem_q;
  logic [RES_W-1:0]   root_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [SH_W-1:0]    sq_x;
  logic [SH_W-1:0]    sq_y;
  logic [SH_W-1:0]    sum_d;
  logic [RES_W:0]     rem_next;
  logic [RES_W-1:0]   root_next;

  // Most negative operand maps to 2^(DATA_W-1), which still fits unsigned.
  function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v);
    if (SIGNED && v[DATA_W-1]) return -v;
    return v;
  endfunction

  assign sq_x  = SH_W'(mag_x_q) * SH_W'(mag_x_q);
  assign sq_y  = SH_W'(mag_y_q) * SH_W'(mag_y_q);
  assign sum_d = sq_x + sq_y;

  assign in_ready = (state_q == StIdle);

  isqrt_step #(
    .RES_W(RES_W)
  ) u_step (
    .rem       (rem_q),
    .root      (root_q),
    .bits      (sum_q[SH_W-1 -: 2]),
    .rem_next  (rem_next),
    .root_next (root_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mag_x_q   <= '0;
      mag_y_q   <= '0;
      sum_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_exact <= 1'b0;
    end else if (clr) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            mag_x_q <= abs_op(in_x);
            mag_y_q <= abs_op(in_y);
            state_q <= StSquare;
          end
        end
        StSquare: begin
          sum_q   <= sum_d;
          rem_q   <= '0;
          root_q  <= '0;
          cnt_q   <= CNT_W'(RES_W - 1);
          state_q <= StRoot;
        end
        StRoot: begin
          rem_q  <= rem_next;
          root_q <= root_next;
          sum_q  <= {sum_q[SH_W-3:0], 2'b00};
          if (cnt_q == '0) state_q <= StDone;
          else cnt_q <= cnt_q - 1'b1;
        end
        StDone: begin
          // First DONE cycle publishes the result; later cycles wait for the consumer.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_exact <= (rem_q == '0);
            if (ROUND && (rem_q > {1'b0, root_q})) out_mag <= root_q + 1'b1;
            else out_mag <= root_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hypot_isqrt_seq.sv
// Bench for hypot_isqrt_seq: five parameter sets run side by side, each with
// directed literal cases followed by a random sweep against a cycle-level model.
module tb_hypot_isqrt_seq;

  localparam int NCFG  = 5;
  localparam int NDIR  = 18;
  localparam int NCYC  = 20000;
  localparam int LIMIT = 60000;

  typedef struct packed {
    int cfg;
    int kind;  // 0 plain, 1 back-pressure, 2 clr abort, 3 rst abort
    int x;
    int y;
    int mag;
    bit exact;
  } dir_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit done [NCFG];

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic dir_t mk(input int c, input int k, input int x, input int y,
                              input int m, input bit e);
    dir_t d;
    d.cfg = c; d.kind = k; d.x = x; d.y = y; d.mag = m; d.exact = e;
    return d;
  endfunction

  // cfg 0: 8b unsigned floor, 1: 8b unsigned round, 2: 8b signed floor,
  // cfg 3: 12b unsigned round, 4: 12b signed floor
  function automatic dir_t dir_entry(input int i);
    case (i)
      0:  return mk(0, 0, 0, 0, 0, 1'b1);
      1:  return mk(0, 0, 3, 4, 5, 1'b1);
      2:  return mk(0, 1, 255, 255, 360, 1'b0);
      3:  return mk(0, 2, 100, 7, 360, 1'b0);   // outputs keep the last result
      4:  return mk(0, 3, 200, 9, 0, 1'b0);     // reset clears outputs
      5:  return mk(0, 0, 5, 12, 13, 1'b1);
      6:  return mk(1, 0, 255, 255, 361, 1'b0);
      7:  return mk(1, 0, 3, 4, 5, 1'b1);
      8:  return mk(1, 0, 1, 1, 1, 1'b0);
      9:  return mk(1, 0, 1, 2, 2, 1'b0);
      10: return mk(1, 0, 2, 2, 3, 1'b0);
      11: return mk(2, 0, -128, -128, 181, 1'b0);
      12: return mk(2, 0, -6, 8, 10, 1'b1);
      13: return mk(2, 0, 127, -128, 180, 1'b0);
      14: return mk(3, 0, 4095, 4095, 5791, 1'b0);
      15: return mk(3, 0, 300, 400, 500, 1'b1);
      16: return mk(4, 0, -2048, -2048, 2896, 1'b0);
      default: return mk(4, 0, -33, 56, 65, 1'b1);
    endcase
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int          G  = g;
    localparam int unsigned DW = (g >= 3) ? 12 : 8;
    localparam bit          SG = (g == 2 || g == 4);
    localparam bit          RD = (g == 1 || g == 3);
    localparam int unsigned RW = DW + 1;

    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_x = '0;
    logic [DW-1:0] in_y = '0;
    logic          in_ready;
    logic          out_valid;
    logic [RW-1:0] out_mag;
    logic          out_exact;

    bit     m_busy = 1'b0;
    bit     m_valid = 1'b0;
    bit     m_exact = 1'b0;
    bit     p_exact = 1'b0;
    int     m_cnt = 0;
    longint m_mag = 0;
    longint p_mag = 0;

    hypot_isqrt_seq #(
      .DATA_W(DW),
      .SIGNED(SG),
      .ROUND (RD)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_x     (in_x),
      .in_y     (in_y),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_mag  (out_mag),
      .out_exact(out_exact)
    );

    function automatic void ref_result(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                       output longint mag, output bit exact);
      longint vx, vy, s, r;
      real    sq;
      vx = longint'(x);
      vy = longint'(y);
      if (SG && x[DW-1]) vx = vx - (longint'(1) << DW);
      if (SG && y[DW-1]) vy = vy - (longint'(1) << DW);
      s  = vx * vx + vy * vy;
      sq = $sqrt(real'(s));
      r  = longint'(sq);
      while (r * r > s) r--;
      while ((r + 1) * (r + 1) <= s) r++;
      exact = (r * r == s);
      if (RD && (sq - real'(r) > 0.5)) r++;
      mag = r;
    endfunction

    function automatic logic [DW-1:0] pick();
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(DW-1){1'b0}}};
        3:       return {1'b0, {(DW-1){1'b1}}};
        default: return DW'($urandom);
      endcase
    endfunction

    // Timeline model: accept in idle, result visible RW+2 edges later, held until taken.
    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
      end else if (clr) begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
      end else if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          ref_result(in_x, in_y, p_mag, p_exact);
        end
      end else begin
        m_cnt++;
        if (m_valid && out_ready) begin
          m_busy  = 1'b0;
          m_valid = 1'b0;
        end else if (m_cnt == int'(RW) + 2) begin
          m_valid = 1'b1;
          m_mag   = p_mag;
          m_exact = p_exact;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (!rst) begin
        chk($sformatf("c%0d in_ready", G), longint'(in_ready), longint'(!m_busy));
        chk($sformatf("c%0d out_valid", G), longint'(out_valid), longint'(m_valid));
        if (m_valid) begin
          chk($sformatf("c%0d out_mag", G), longint'(out_mag), m_mag);
          chk($sformatf("c%0d out_exact", G), longint'(out_exact), longint'(m_exact));
        end
      end
    end

    task automatic watch_quiet(input string name);
      bit seen;
      seen = 1'b0;
      repeat (30) begin
        @(negedge clk);
        seen |= out_valid;
      end
      chk(name, longint'(seen), 0);
    endtask

    task automatic do_dir(input dir_t e);
      int k;
      @(negedge clk);
      in_x      = DW'(e.x);
      in_y      = DW'(e.y);
      in_valid  = 1'b1;
      out_ready = (e.kind != 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      if (e.kind >= 2) begin
        while (k < 4) begin
          @(negedge clk);
          k++;
        end
        if (e.kind == 2) begin
          clr = 1'b1;
          @(negedge clk);
          clr = 1'b0;
        end else begin
          @(posedge clk);
          #2 rst = 1'b1;
          @(negedge clk);
        end
        chk($sformatf("c%0d abort in_ready", G), longint'(in_ready), 1);
        chk($sformatf("c%0d abort out_valid", G), longint'(out_valid), 0);
        chk($sformatf("c%0d abort out_mag", G), longint'(out_mag), longint'(e.mag));
        chk($sformatf("c%0d abort out_exact", G), longint'(out_exact), longint'(e.exact));
        rst = 1'b0;
        watch_quiet($sformatf("c%0d abort no result", G));
      end else begin
        while (!out_valid && k < 64) begin
          @(negedge clk);
          k++;
        end
        chk($sformatf("c%0d latency (%0d,%0d)", G, e.x, e.y), longint'(k), longint'(RW + 2));
        chk($sformatf("c%0d mag (%0d,%0d)", G, e.x, e.y), longint'(out_mag), longint'(e.mag));
        chk($sformatf("c%0d exact (%0d,%0d)", G, e.x, e.y), longint'(out_exact),
            longint'(e.exact));
        if (e.kind == 1) begin
          repeat (20) @(negedge clk);
          chk($sformatf("c%0d bp out_valid", G), longint'(out_valid), 1);
          chk($sformatf("c%0d bp out_mag", G), longint'(out_mag), longint'(e.mag));
          chk($sformatf("c%0d bp in_ready", G), longint'(in_ready), 0);
          out_ready = 1'b1;
        end
        @(negedge clk);
        chk($sformatf("c%0d taken in_ready", G), longint'(in_ready), 1);
        chk($sformatf("c%0d taken out_valid", G), longint'(out_valid), 0);
      end
    endtask

    initial begin
      dir_t e;
      done[G] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk($sformatf("c%0d reset out_mag", G), longint'(out_mag), 0);
      chk($sformatf("c%0d reset out_exact", G), longint'(out_exact), 0);
      chk($sformatf("c%0d reset out_valid", G), longint'(out_valid), 0);
      chk($sformatf("c%0d reset in_ready", G), longint'(in_ready), 1);
      for (int i = 0; i < NDIR; i++) begin
        e = dir_entry(i);
        if (e.cfg == G) do_dir(e);
      end
      repeat (NCYC) begin
        @(negedge clk);
        in_valid  = ($urandom_range(0, 1) == 1);
        in_x      = pick();
        in_y      = pick();
        out_ready = ($urandom_range(0, 3) != 0);
        clr       = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b1;
      repeat (40) @(negedge clk);
      done[G] = 1'b1;
    end
  end

  initial begin
    int waited;
    bit all_done;
    waited   = 0;
    all_done = 1'b0;
    while (!all_done && waited < LIMIT) begin
      @(negedge clk);
      waited++;
      all_done = 1'b1;
      for (int i = 0; i < NCFG; i++) if (!done[i]) all_done = 1'b0;
    end
    chk("all configs finished", longint'(all_done), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
